// File: rtl/display_pkg.sv
// Shared definitions for the countdown display: FSM state encoding,
// seven-segment patterns and the largest count that can be shown.
package display_pkg;

    // FSM state type with legacy-style constant encodings
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_LATCH = 2'd2;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

    // Two digits can show at most 99 seconds
    localparam logic [6:0] MAX_COUNT = 7'd99;

    // Clamp an incoming count so the BCD result always fits in two digits
    function automatic logic [6:0] saturate(input logic [6:0] value);
        return (value > MAX_COUNT) ? MAX_COUNT : value;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder. Codes 10-15 are
// not valid BCD and show as a dark digit.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Table lookup; anything outside 0-9 falls through to blank
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_DIGIT[0];
            4'd1:    o_seg = SEG_DIGIT[1];
            4'd2:    o_seg = SEG_DIGIT[2];
            4'd3:    o_seg = SEG_DIGIT[3];
            4'd4:    o_seg = SEG_DIGIT[4];
            4'd5:    o_seg = SEG_DIGIT[5];
            4'd6:    o_seg = SEG_DIGIT[6];
            4'd7:    o_seg = SEG_DIGIT[7];
            4'd8:    o_seg = SEG_DIGIT[8];
            4'd9:    o_seg = SEG_DIGIT[9];
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_display.sv
// Two-digit countdown display. A binary count is converted to BCD by a
// one-shift-per-cycle double-dabble engine and latched onto HEX7 (tens)
// and HEX6 (ones). A strobe arriving during a conversion is parked in a
// one-entry pending slot (latest wins). A latched zero blinks the display.
module countdown_display
    import display_pkg::*;
#(
    parameter int BLINK_TICKS = 50_000_000,
    parameter int BLINK_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] count_in,
    input  logic       count_valid,
    output logic       busy,
    output logic [6:0] HEX6,
    output logic [6:0] HEX7
);

    localparam int CW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_TICKS - 1);

    // {tens[3:0], ones[3:0], binary[6:0]} working register of the converter
    state_t        r_state;
    logic [14:0]   r_shift;
    logic [2:0]    r_shiftCnt;
    logic          r_busy;
    logic          r_pendValid;
    logic [6:0]    r_pendValue;
    logic [6:0]    r_segOnes;
    logic [6:0]    r_segTens;
    logic          r_isZero;
    logic          r_blank;
    logic [CW-1:0] r_blinkCnt;

    logic [14:0]   w_adj;
    logic [6:0]    w_segOnes;
    logic [6:0]    w_segTens;

    seg7_decoder u_decTens (
        .i_bcd (r_shift[14:11]),
        .o_seg (w_segTens)
    );

    seg7_decoder u_decOnes (
        .i_bcd (r_shift[10:7]),
        .o_seg (w_segOnes)
    );

    // Add-3 correction of each BCD nibble that would overflow on the next shift
    always_comb begin
        w_adj = r_shift;
        if (r_shift[14:11] >= 4'd5) begin
            w_adj[14:11] = r_shift[14:11] + 4'd3;
        end
        if (r_shift[10:7] >= 4'd5) begin
            w_adj[10:7] = r_shift[10:7] + 4'd3;
        end
    end

    // Conversion FSM: load, seven corrected shifts, then latch the digits.
    // A strobe seen in LATCH is taken directly so no cycle is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_shiftCnt  <= '0;
            r_busy      <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendValue <= '0;
            r_segOnes   <= SEG_BLANK;
            r_segTens   <= SEG_BLANK;
            r_isZero    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (count_valid) begin
                        r_shift    <= {8'd0, saturate(count_in)};
                        r_shiftCnt <= '0;
                        r_state    <= ST_SHIFT;
                        r_busy     <= 1'b1;
                    end else if (r_pendValid) begin
                        r_shift     <= {8'd0, r_pendValue};
                        r_shiftCnt  <= '0;
                        r_pendValid <= 1'b0;
                        r_state     <= ST_SHIFT;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_shift    <= w_adj << 1;
                    r_shiftCnt <= r_shiftCnt + 3'd1;
                    if (r_shiftCnt == 3'd6) begin
                        r_state <= ST_LATCH;
                    end
                    if (count_valid) begin
                        r_pendValid <= 1'b1;
                        r_pendValue <= saturate(count_in);
                    end
                end
                ST_LATCH: begin
                    r_segTens  <= w_segTens;
                    r_segOnes  <= w_segOnes;
                    r_isZero   <= (r_shift[14:7] == 8'd0);
                    r_shiftCnt <= '0;
                    if (count_valid) begin
                        r_shift     <= {8'd0, saturate(count_in)};
                        r_pendValid <= 1'b0;
                        r_state     <= ST_SHIFT;
                    end else if (r_pendValid) begin
                        r_shift     <= {8'd0, r_pendValue};
                        r_pendValid <= 1'b0;
                        r_state     <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Blink timer: toggles the blank flag every BLINK_TICKS cycles while a
    // zero is shown; every latch restarts it unblanked
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blinkCnt <= '0;
            r_blank    <= 1'b0;
        end else if (r_state == ST_LATCH) begin
            r_blinkCnt <= '0;
            r_blank    <= 1'b0;
        end else if ((BLINK_EN != 0) && r_isZero) begin
            if (r_blinkCnt == BLINK_LAST) begin
                r_blinkCnt <= '0;
                r_blank    <= ~r_blank;
            end else begin
                r_blinkCnt <= r_blinkCnt + CW'(1);
            end
        end
    end

    assign busy = r_busy;
    assign HEX6 = r_blank ? SEG_BLANK : r_segOnes;
    assign HEX7 = r_blank ? SEG_BLANK : r_segTens;

endmodule

// File: tb/tb_countdown_display.sv
// Testbench for countdown_display. A behavioural model tracks accepted
// values, pending strobes and display timing in plain arithmetic and
// pushes the expected outputs for every clock edge into a scoreboard
// queue; a separate monitor pops and compares on the falling edge.
module tb_countdown_display;

    localparam int TICKS = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       count_valid;
    logic [6:0] count_in;
    logic       busy;
    logic [6:0] HEX6;
    logic [6:0] HEX7;

    countdown_display #(
        .BLINK_TICKS (TICKS),
        .BLINK_EN    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .count_valid (count_valid),
        .busy        (busy),
        .HEX6        (HEX6),
        .HEX7        (HEX7)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         busy;
        logic [6:0] hex7;
        logic [6:0] hex6;
    } expect_t;

    expect_t scoreQ[$];
    int checks = 0;
    int errors = 0;

    // Reference model state, expressed in seconds and edge numbers
    int cyc      = 0;
    bit mBusy    = 1'b0;
    int mVal     = 0;
    int mLatchAt = 0;
    bit mPend    = 1'b0;
    int mPendVal = 0;
    int mShown   = -1;
    int mShownAt = 0;

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function void startConv(input int v);
        mBusy    = 1'b1;
        mVal     = v;
        mLatchAt = cyc + 8;
    endfunction

    // Model: advance on every rising edge using the inputs the DUT samples
    initial begin : model
        expect_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mBusy  = 1'b0;
                mPend  = 1'b0;
                mShown = -1;
            end else if (!mBusy) begin
                if (count_valid) startConv(sat(int'(count_in)));
            end else if (cyc == mLatchAt) begin
                mShown   = mVal;
                mShownAt = cyc;
                if (count_valid) begin
                    startConv(sat(int'(count_in)));
                    mPend = 1'b0;
                end else if (mPend) begin
                    startConv(mPendVal);
                    mPend = 1'b0;
                end else begin
                    mBusy = 1'b0;
                end
            end else if (count_valid) begin
                mPend    = 1'b1;
                mPendVal = sat(int'(count_in));
            end
            e.cyc  = cyc;
            e.busy = mBusy;
            if (mShown < 0 || (mShown == 0 && (((cyc - mShownAt) / TICKS) % 2) == 1)) begin
                e.hex7 = 7'b1111111;
                e.hex6 = 7'b1111111;
            end else begin
                e.hex7 = segOf(mShown / 10);
                e.hex6 = segOf(mShown % 10);
            end
            scoreQ.push_back(e);
        end
    end

    task automatic checkOutput(input expect_t e);
        checks++;
        if (busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL busy cyc=%0d actual=%b required=%b", e.cyc, busy, e.busy);
        end
        checks++;
        if ({HEX7, HEX6} !== {e.hex7, e.hex6}) begin
            errors++;
            $display("[TB] FAIL hex cyc=%0d actual HEX7=%b HEX6=%b required HEX7=%b HEX6=%b",
                     e.cyc, HEX7, HEX6, e.hex7, e.hex6);
        end
    endtask

    // Monitor: compare the registered outputs away from the active edge
    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk);
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Drive one cycle's inputs just after a rising edge
    task automatic applyStimulus(input bit v, input logic [6:0] c, input bit r);
        @(posedge clk);
        #1;
        rst         = r;
        count_valid = v;
        count_in    = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 7'($urandom_range(0, 127)), 1'b0);
        end
    endtask

    initial begin : stimulus
        rst         = 1'b1;
        count_valid = 1'b0;
        count_in    = '0;
        applyStimulus(1'b0, 7'd0, 1'b1);
        idle(3);

        $display("[TB] single conversion of 42");
        applyStimulus(1'b1, 7'd42, 1'b0);
        idle(12);

        $display("[TB] saturation of 123");
        applyStimulus(1'b1, 7'd123, 1'b0);
        idle(12);

        $display("[TB] pending overwrite 30/29/28");
        applyStimulus(1'b1, 7'd30, 1'b0);
        idle(2);
        applyStimulus(1'b1, 7'd29, 1'b0);
        idle(1);
        applyStimulus(1'b1, 7'd28, 1'b0);
        idle(15);

        $display("[TB] zero blink then 07");
        applyStimulus(1'b1, 7'd0, 1'b0);
        idle(90);
        applyStimulus(1'b1, 7'd7, 1'b0);
        idle(60);

        $display("[TB] reset mid-conversion with pending value");
        applyStimulus(1'b1, 7'd55, 1'b0);
        idle(1);
        applyStimulus(1'b1, 7'd54, 1'b0);
        applyStimulus(1'b1, 7'd11, 1'b1);
        idle(25);

        $display("[TB] randomized strobes");
        for (int k = 0; k < 40; k++) begin
            logic [6:0] v;
            v = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
            if ($urandom_range(0, 15) == 0) begin
                applyStimulus(1'($urandom_range(0, 1)), v, 1'b1);
            end else begin
                applyStimulus(1'b1, v, 1'b0);
            end
            idle(int'($urandom_range(0, 12)));
        end
        idle(50);

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
